// File: rtl/bk_pipe_adder.sv
// Pipelined Brent-Kung parallel-prefix adder/subtractor with valid/ready flow control.
// The prefix tree is sized to the next power of two above N; register ranks sit at evenly spaced tree levels.
module bk_pipe_adder #(
  parameter int N            = 32,
  parameter int PIPE_STAGES  = 2,
  parameter int SIGNED_FLAGS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int LOG    = (N <= 2) ? 1 : $clog2(N);
  localparam int P      = 1 << LOG;
  localparam int LEVELS = 2 * LOG - 1;

  // One tree level's worth of state: valid bit, carry-in, raw propagate for the
  // final XOR, and the running group generate/propagate vectors.
  typedef struct packed {
    logic         v;
    logic         c;
    logic [P-1:0] x;
    logic [P-1:0] g;
    logic [P-1:0] p;
  } stg_t;

  function automatic bit is_reg(input int lvl);
    bit hit;
    hit = 1'b0;
    for (int k = 1; k < PIPE_STAGES; k++)
      if ((k * LEVELS) / PIPE_STAGES == lvl) hit = 1'b1;
    return hit;
  endfunction

  // Levels 1..LOG form the up-sweep; LOG+1..LEVELS the down-sweep.
  function automatic stg_t sweep(input stg_t s, input int lvl);
    stg_t r;
    int   d;
    int   span;
    r = s;
    if (lvl <= LOG) begin
      d    = lvl;
      span = 1 << (d - 1);
      for (int i = 0; i < P; i++)
        if ((i % (1 << d)) == (1 << d) - 1 && i >= span) begin
          r.g[i] = s.g[i] | (s.p[i] & s.g[i-span]);
          r.p[i] = s.p[i] & s.p[i-span];
        end
    end else begin
      d    = 2 * LOG - lvl;
      span = 1 << (d - 1);
      for (int i = 0; i < P; i++)
        if (i >= (1 << d) && (i % (1 << d)) == span - 1) begin
          r.g[i] = s.g[i] | (s.p[i] & s.g[i-span]);
          r.p[i] = s.p[i] & s.p[i-span];
        end
    end
    return r;
  endfunction

  logic         adv;
  logic [N-1:0] b_eff;
  logic         c_eff;
  stg_t         s0;
  stg_t         lvl_out [0:LEVELS];
  stg_t         lvl_in  [1:LEVELS];

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    b_eff = sub ? ~b : b;
    c_eff = sub | cin;
    // NOTE: the whole bundle gets a default first so padding bits and every field are always assigned (no latches).
    s0             = '0;
    s0.v           = in_valid;
    s0.c           = c_eff;
    s0.x[N-1:0]    = a ^ b_eff;
    s0.p[N-1:0]    = a ^ b_eff;
    s0.g[N-1:0]    = a & b_eff;
    // Carry-in folded in as a (G=cin, P=0) group at position -1.
    s0.g[0]        = s0.g[0] | (s0.p[0] & c_eff);
    s0.p[0]        = 1'b0;
  end

  assign lvl_out[0] = s0;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam bit REG = is_reg(l);
    if (REG) begin : g_rank
      stg_t r;
      // NOTE: non-blocking assignment so every rank samples its predecessor's pre-edge value.
      always_ff @(posedge clk) begin
        if (rst)      r <= '0;
        else if (adv) r <= lvl_out[l];
      end
      assign lvl_in[l+1] = r;
    end else begin : g_wire
      assign lvl_in[l+1] = lvl_out[l];
    end
    assign lvl_out[l+1] = sweep(lvl_in[l+1], l + 1);
  end

  stg_t         f;
  logic [P-1:0] carry;
  logic [N-1:0] sum_d;
  logic         cout_d;
  logic         ovf_d;
  logic         unused_bits;

  assign f      = lvl_out[LEVELS];
  assign carry  = {f.g[P-2:0], f.c};
  assign sum_d  = f.x[N-1:0] ^ carry[N-1:0];
  assign cout_d = f.g[N-1];
  assign ovf_d  = (SIGNED_FLAGS != 0) ? (carry[N-1] ^ cout_d) : 1'b0;
  assign unused_bits = ^{f.p, f.x, f.g, carry};

  // Output rank; datapath state is cleared on reset along with the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      out_valid <= f.v;
      sum       <= sum_d;
      cout      <= cout_d;
      ovf       <= ovf_d;
      zero      <= ~|sum_d;
    end
  end

endmodule

// File: tb/tb_bk_pipe_adder.sv
// Self-checking bench: five adder configurations share one stimulus stream; each has its own
// in-order scoreboard fed from an arithmetic reference model.
module tb_bk_pipe_adder;

  localparam int ND = 5;
  localparam int NS [ND] = '{16, 24, 16, 2, 64};
  localparam int SS [ND] = '{2, 3, 4, 1, 11};

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          t;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;

  logic        rdy [ND];
  logic        ovl [ND];
  logic        co  [ND];
  logic        of  [ND];
  logic        zr  [ND];
  logic [63:0] sw  [ND];

  logic [15:0] s0;
  logic [23:0] s1;
  logic [15:0] s2;
  logic [1:0]  s3;
  logic [63:0] s4;

  assign sw[0] = 64'(s0);
  assign sw[1] = 64'(s1);
  assign sw[2] = 64'(s2);
  assign sw[3] = 64'(s3);
  assign sw[4] = s4;

  int   n_asserts = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  bit   full_rate = 1'b0;
  exp_t q [ND][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bk_pipe_adder #(.N(16), .PIPE_STAGES(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .sub(sub), .out_valid(ovl[0]), .out_ready(out_ready), .sum(s0), .cout(co[0]),
    .ovf(of[0]), .zero(zr[0]));
  bk_pipe_adder #(.N(24), .PIPE_STAGES(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .a(a[23:0]), .b(b[23:0]),
    .cin(cin), .sub(sub), .out_valid(ovl[1]), .out_ready(out_ready), .sum(s1), .cout(co[1]),
    .ovf(of[1]), .zero(zr[1]));
  bk_pipe_adder #(.N(16), .PIPE_STAGES(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .sub(sub), .out_valid(ovl[2]), .out_ready(out_ready), .sum(s2), .cout(co[2]),
    .ovf(of[2]), .zero(zr[2]));
  bk_pipe_adder #(.N(2), .PIPE_STAGES(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .a(a[1:0]), .b(b[1:0]),
    .cin(cin), .sub(sub), .out_valid(ovl[3]), .out_ready(out_ready), .sum(s3), .cout(co[3]),
    .ovf(of[3]), .zero(zr[3]));
  bk_pipe_adder #(.N(64), .PIPE_STAGES(11)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[4]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ovl[4]), .out_ready(out_ready), .sum(s4), .cout(co[4]),
    .ovf(of[4]), .zero(zr[4]));

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_asserts++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain (N+1)-bit arithmetic; overflow from operand/result signs.
  function automatic exp_t model(input int n, input logic [63:0] av, input logic [63:0] bv,
                                 input logic ci, input logic s, input int t, input bit lat);
    exp_t        e;
    logic [64:0] m;
    logic [64:0] full;
    logic [63:0] bb;
    m      = (65'd1 << n) - 65'd1;
    bb     = s ? ~bv : bv;
    full   = ({1'b0, av} & m) + ({1'b0, bb} & m) + 65'(s ? 1'b1 : ci);
    e.sum  = full[63:0] & m[63:0];
    e.cout = full[n];
    e.ovf  = (av[n-1] == bb[n-1]) && (e.sum[n-1] != av[n-1]);
    e.zero = (e.sum == 64'd0);
    e.t    = t;
    e.lat  = lat;
    return e;
  endfunction

  function automatic logic [71:0] res(input int d);
    return {5'd0, co[d], of[d], zr[d], sw[d]};
  endfunction

  // Monitor: inputs and outputs are stable at the falling edge, so transfers that the
  // next rising edge will perform can be decided here.
  bit          stall_prev [ND];
  logic [71:0] prev_res   [ND];
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < ND; d++) begin
        q[d].delete();
        stall_prev[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        exp_t e;
        if (stall_prev[d]) begin
          chk($sformatf("hold_valid_d%0d", d), 72'(ovl[d]), 72'd1);
          chk($sformatf("hold_stable_d%0d", d), res(d), prev_res[d]);
        end
        if (in_valid && rdy[d])
          q[d].push_back(model(NS[d], a, b, cin, sub, cyc, full_rate));
        if (ovl[d] && out_ready) begin
          chk($sformatf("no_spurious_d%0d", d), 72'(q[d].size() != 0), 72'd1);
          if (q[d].size() != 0) begin
            e = q[d].pop_front();
            chk($sformatf("result_d%0d", d), res(d), {5'd0, e.cout, e.ovf, e.zero, e.sum});
            if (e.lat && full_rate)
              chk($sformatf("latency_d%0d", d), 72'(cyc - e.t), 72'(SS[d]));
          end
        end
        stall_prev[d] = ovl[d] && !out_ready;
        prev_res[d]   = res(d);
      end
    end
  end

  task automatic drive(input logic [63:0] av, input logic [63:0] bv, input logic ci, input logic s);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = ci;
    sub      = s;
  endtask

  // Presents one item for exactly one cycle; returns 1 time unit after the accepting edge.
  task automatic send_one(input logic [63:0] av, input logic [63:0] bv, input logic ci, input logic s);
    @(posedge clk); #1;
    drive(av, bv, ci, s);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   k;
    int   guard;
    bit   accepted;
    logic [63:0] av;
    logic [63:0] bv;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, with out_ready low so in_ready depends only on out_valid.
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_out_valid_d%0d", d), 72'(ovl[d]), 72'd0);
      chk($sformatf("rst_in_ready_d%0d", d), 72'(rdy[d]), 72'd1);
      chk($sformatf("rst_result_d%0d", d), res(d), 72'd0);
    end

    out_ready = 1'b1;
    full_rate = 1'b1;

    // Directed vectors on the N=16, 2-stage instance.
    send_one(64'hFFFF, 64'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("dir_add_valid", 72'(ovl[0]), 72'd1);
    chk("dir_add_wrap", res(0), {5'd0, 1'b1, 1'b0, 1'b1, 64'h0000});

    send_one(64'h8000, 64'h0001, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("dir_sub_ovf", res(0), {5'd0, 1'b1, 1'b1, 1'b0, 64'h7FFF});

    send_one(64'h0003, 64'h0005, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("dir_sub_borrow", res(0), {5'd0, 1'b0, 1'b0, 1'b0, 64'hFFFE});

    send_one(64'hFFFFFF, 64'hFFFFFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("dir_all_ones_n16", res(0), {5'd0, 1'b1, 1'b0, 1'b0, 64'hFFFF});
    @(posedge clk); #1;
    chk("dir_all_ones_n24", res(1), {5'd0, 1'b1, 1'b0, 1'b0, 64'hFFFFFF});

    // Exhaustive N=2 at full rate (also exercises every instance on small operands).
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      drive(64'(i & 3), 64'((i >> 2) & 3), i[4], i[5]);
    end

    // Random full-rate stream.
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;

    // Backpressure: source follows the 4-stage instance's handshake.
    full_rate = 1'b0;
    k = 0;
    guard = 0;
    av = {$urandom, $urandom};
    bv = {$urandom, $urandom};
    drive(av, bv, 1'($urandom), 1'($urandom));
    while (k < 20 && guard < 400) begin
      if (guard >= 8 && guard <= 13) out_ready = 1'b0;
      else                           out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      accepted = rdy[2];
      if (guard == 13) begin
        chk("bp_full_out_valid", 72'(ovl[2]), 72'd1);
        chk("bp_full_in_ready", 72'(rdy[2]), 72'd0);
        chk("bp_full_in_ready_n16s2", 72'(rdy[0]), 72'd0);
      end
      @(posedge clk); #1;
      if (accepted) begin
        k++;
        drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      end
      guard++;
    end
    chk("bp_items_sent", 72'(k), 72'd20);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++)
      chk($sformatf("bp_drained_d%0d", d), 72'(q[d].size()), 72'd0);

    // Reset with three items in flight.
    full_rate = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(64'(i + 1), 64'(i + 7), 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("mid_rst_out_valid_d%0d", d), 72'(ovl[d]), 72'd0);
      chk($sformatf("mid_rst_in_ready_d%0d", d), 72'(rdy[d]), 72'd1);
      chk($sformatf("mid_rst_result_d%0d", d), res(d), 72'd0);
    end
    send_one(64'h0010, 64'h0020, 1'b0, 1'b0);
    chk("post_rst_empty", 72'(ovl[0]), 72'd0);
    @(posedge clk); #1;
    chk("post_rst_valid", 72'(ovl[0]), 72'd1);
    chk("post_rst_sum", res(0), {5'd0, 1'b0, 1'b0, 1'b0, 64'h0030});
    @(posedge clk); #1;
    chk("post_rst_alone", 72'(ovl[0]), 72'd0);
    repeat (12) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++)
      chk($sformatf("final_drained_d%0d", d), 72'(q[d].size()), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
